str_decim_mc: RTL
=================

Name: str_decim_mc

Overview:
- Multi-channel AXI-Stream decimator for the LPDAQ sample path.
- Input is CH time-interleaved channels (ch0, ch1, …, chCH-1 form one frame). The block outputs one frame for every 2^K input frames.
- Runtime mode selects plain sample-pick or boxcar average.
- Asserts tlast on the final sample of every LAST-th output frame, giving packet framing for the downstream DMA.

Parameters:
- DW, 24, sample width (signed two's complement).
- CH, 2, number of interleaved channels (≥1).
- KMAX, 8, maximum log2 decimation ratio (ratio up to 256).
- LAST, 16000, output frames per tlast packet (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_log2r  in  clog2(KMAX+1)  log2 of decimation ratio K; values >KMAX are clamped to KMAX.
- cfg_mode  in  1  0 = pick first frame of block, 1 = boxcar average.
- s_axis_tdata  in  DW  signed input sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DW  signed decimated sample.
- m_axis_tlast  out  1  last sample of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

Behaviour:
- **Reset:** all outputs are 0 except s_axis_tready. s_axis_tready = !m_axis_tvalid || m_axis_tready, so it is 1 after reset. Counters, accumulators and shadow config are cleared; shadow K = 0, mode = pick.
- **Accept rule:** a sample is accepted when s_axis_tvalid && s_axis_tready.
- **Counters:**
  - ch_idx counts 0..CH-1 and increments on every accept.
  - On wrap, frm_idx counts 0..2^K-1.
  - On frm_idx wrap, out_cnt counts 0..LAST-1 (one step per emitted frame).
- **Config latch:** cfg_log2r (clamped) and cfg_mode are latched into shadow registers on accept of ch_idx=0, frm_idx=0, i.e. block start. Mid-block changes have no effect until the next block.
- **Pick mode:**
  - Samples with frm_idx=0 are emitted unchanged.
  - All other samples are consumed and dropped (still accepted).
- **Average mode:**
  - There is one accumulator per channel, width DW+KMAX, signed.
  - frm_idx=0 loads acc[ch] = x.
  - Intermediate frames do acc[ch] += x.
  - On frm_idx=2^K-1, the block emits (acc[ch]+x) >>> K, an arithmetic shift that floors toward −inf, truncated to DW bits (always fits).
  - K=0 passes every sample unchanged in both modes.
- **Output register:** single stage.
  - An accept that produces an output loads m_axis_tdata and m_axis_tlast and sets m_axis_tvalid on the next edge (latency 1 cycle).
  - An accept that produces no output leaves m_axis_tvalid cleared if m_axis_tready, else held.
  - m_axis_tdata and m_axis_tvalid are held stable while m_axis_tvalid && !m_axis_tready (AXI rule).
  - When the output stage is empty or drained in the same cycle, full throughput is 1 sample/cycle.
- **tlast:** m_axis_tlast = 1 only on the emitted sample with ch_idx=CH-1 and out_cnt=LAST-1; out_cnt then wraps to 0.
- **Backpressure:** s_axis_tready drops only when the output register is full and m_axis_tready=0. Dropped samples (pick mode, non-final average frames) are still gated by s_axis_tready, which keeps input order deterministic.
- **Reset mid-operation:** asynchronous clear returns the block to the frame/block/packet start. Any partial accumulations are discarded and the in-flight output is lost.
- **Width rules:** the accumulator cannot overflow (2^KMAX·(2^(DW-1)) fits DW+KMAX bits signed). All counters are sized by clog2 of their range.

Test Plan:
- CH=2, K=0, pick, m_ready=1, input 1..8 → output 1..8 identical, 1-cycle latency, tlast per LAST.
- CH=2, K=2, pick, input frames (1,−1),(2,−2),(3,−3),(4,−4),(5,−5)… → outputs 1,−1,5,−5,…; 3 of every 4 frames dropped.
- CH=1, K=2, average, input 3,4,5,7 → single output 4 (19>>>2). Input −1,−1,−1,−2 → −2 (floor of −5/4).
- LAST=3, CH=2, K=1, pick, 12 input frames → 6 output frames; tlast only on ch1 of output frames 3 and 6.
- Random m_axis_tready toggling (50%), average mode → output sequence matches the golden model. tdata is stable while stalled; no sample is lost or duplicated.
- Change cfg_log2r 1→3 mid-block → the current block completes at ratio 2 and the next block uses ratio 8. Assert rst_n low mid-block → all outputs 0, and the first post-reset block starts fresh.

Source files
------------

// File: rtl/str_decim_mc.sv
// Multi-channel AXI-Stream decimator: pick-first or boxcar-average over 2^K interleaved frames.
// Latency: one cycle from the accepting edge to m_axis_tvalid for any sample that produces output.
// Backpressure: s_axis_tready = !m_axis_tvalid || m_axis_tready, so dropped samples also stall.
module str_decim_mc #(
    parameter int DW   = 24,
    parameter int CH   = 2,
    parameter int KMAX = 8,
    parameter int LAST = 16000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(KMAX+1)-1:0]    cfg_log2r,
    input  logic                         cfg_mode,
    input  logic [DW-1:0]                s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    output logic [DW-1:0]                m_axis_tdata,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready
);

    localparam int KW = $clog2(KMAX + 1);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int FW = (KMAX > 0) ? KMAX : 1;
    localparam int OW = (LAST > 1) ? $clog2(LAST) : 1;
    localparam int AW = DW + KMAX;

    // Counters and block-level shadow configuration
    logic [CW-1:0]        ch_q;
    logic [FW-1:0]        frm_q;
    logic [OW-1:0]        out_q;
    logic [KW-1:0]        k_q;
    logic                 mode_q;
    logic signed [AW-1:0] acc_q [CH];

    // Output register
    logic [DW-1:0]        m_dat_q;
    logic                 m_last_q;
    logic                 m_vld_q;

    // Combinational datapath
    logic                 accept;
    logic                 blk_start;
    logic [KW-1:0]        k_cfg;
    logic [KW-1:0]        k_eff;
    logic                 mode_eff;
    logic [FW:0]          ratio;
    logic                 frm_end;
    logic                 ch_end;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shifted;
    logic                 emit_d;
    logic [DW-1:0]        m_dat_d;
    logic                 m_last_d;

    assign s_axis_tready = !m_vld_q || m_axis_tready;
    assign m_axis_tdata  = m_dat_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tvalid = m_vld_q;

    // Resolve the ratio/mode that applies to the current sample, then form pick/average result.
    // At block start the live config is used so the first sample already follows the new setting.
    always_comb begin
        accept    = s_axis_tvalid && s_axis_tready;
        blk_start = (ch_q == '0) && (frm_q == '0);
        k_cfg     = (cfg_log2r > KW'(KMAX)) ? KW'(KMAX) : cfg_log2r;
        k_eff     = blk_start ? k_cfg : k_q;
        mode_eff  = blk_start ? cfg_mode : mode_q;
        ratio     = {{FW{1'b0}}, 1'b1} << k_eff;
        frm_end   = ({1'b0, frm_q} == (ratio - {{FW{1'b0}}, 1'b1}));
        ch_end    = (ch_q == CW'(CH - 1));
        x_ext     = {{KMAX{s_axis_tdata[DW-1]}}, s_axis_tdata};
        sum       = (frm_q == '0) ? x_ext : (acc_q[ch_q] + x_ext);
        shifted   = sum >>> k_eff;
        emit_d    = mode_eff ? frm_end : (frm_q == '0);
        m_dat_d   = mode_eff ? DW'(shifted) : s_axis_tdata;
        m_last_d  = ch_end && (out_q == OW'(LAST - 1));
    end

    // Channel / frame / packet counters advance on every accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q  <= '0;
            frm_q <= '0;
            out_q <= '0;
        end else if (accept) begin
            if (ch_end) begin
                ch_q <= '0;
                if (frm_end) begin
                    frm_q <= '0;
                    out_q <= (out_q == OW'(LAST - 1)) ? '0 : out_q + OW'(1);
                end else begin
                    frm_q <= frm_q + FW'(1);
                end
            end else begin
                ch_q <= ch_q + CW'(1);
            end
        end
    end

    // Shadow config is captured only at block start so mid-block changes wait for the next block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            mode_q <= 1'b0;
        end else if (accept && blk_start) begin
            k_q    <= k_cfg;
            mode_q <= cfg_mode;
        end
    end

    // Per-channel running sum; frame 0 reloads so stale blocks never leak forward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                acc_q[i] <= '0;
            end
        end else if (accept) begin
            acc_q[ch_q] <= sum;
        end
    end

    // Single-stage output register, held while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dat_q  <= '0;
            m_last_q <= 1'b0;
            m_vld_q  <= 1'b0;
        end else if (accept && emit_d) begin
            m_dat_q  <= m_dat_d;
            m_last_q <= m_last_d;
            m_vld_q  <= 1'b1;
        end else if (m_axis_tready) begin
            m_vld_q  <= 1'b0;
        end
    end

endmodule
